// File: rtl/dytr_pkg.sv
// Shared types and constants for the DyTR3 sequencing controller.
package dytr_pkg;

    typedef enum logic [1:0] {
        ST_NORM = 2'd0,
        ST_TTR  = 2'd1,
        ST_REC  = 2'd2,
        ST_FAIL = 2'd3
    } dytr_state_t;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b10;

    // Width of a counter that must hold 0..max_retry inclusive.
    function automatic int retry_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/dytr_rec_timer.sv
// Loadable down-counter timing one recovery episode; done is high while the count is zero.
// load has priority over en; the count saturates at zero.
module dytr_rec_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/dytr_seq_ctrl.sv
// DyTR3 sequencer: normal / triple-time-redundant execution with bounded rollback retry.
// All outputs registered (one-cycle latency from inputs); a started triple always completes.
module dytr_seq_ctrl
    import dytr_pkg::*;
#(
    parameter int REC_CYCLES = 4,
    parameter int MAX_RETRY  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          userMode,
    input  logic                          userFetch,
    input  logic                          fail,
    output logic                          modeS,
    output logic                          fetchA,
    output logic [1:0]                    ctr,
    output logic                          errFlag,
    output logic                          userFail,
    output logic [retry_w(MAX_RETRY)-1:0] retryCnt
);

    localparam int RW = retry_w(MAX_RETRY);
    localparam int TW = (REC_CYCLES > 1) ? $clog2(REC_CYCLES) : 1;
    localparam logic [RW-1:0] MAX_R  = RW'(MAX_RETRY);
    localparam logic [TW-1:0] REC_LD = TW'(REC_CYCLES - 1);

    dytr_state_t   r_state, w_state_nx;
    logic [1:0]    r_ctr, w_ctr_nx;
    logic          r_modeS, w_modeS_nx;
    logic          r_fetchA, w_fetchA_nx;
    logic          r_err, w_err_nx;
    logic          r_ufail, w_ufail_nx;
    logic [RW-1:0] r_retry, w_retry_nx;
    logic          w_tmr_load, w_tmr_en, w_tmr_done;

    dytr_rec_timer #(.W(TW)) u_rec_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_en       (w_tmr_en),
        .i_load_val (REC_LD),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_NORM;
            r_ctr    <= PH0;
            r_modeS  <= 1'b0;
            r_fetchA <= 1'b0;
            r_err    <= 1'b0;
            r_ufail  <= 1'b0;
            r_retry  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_ctr    <= w_ctr_nx;
            r_modeS  <= w_modeS_nx;
            r_fetchA <= w_fetchA_nx;
            r_err    <= w_err_nx;
            r_ufail  <= w_ufail_nx;
            r_retry  <= w_retry_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ctr_nx    = PH0;
        w_modeS_nx  = r_modeS;
        w_fetchA_nx = 1'b0;
        w_err_nx    = 1'b0;
        w_ufail_nx  = r_ufail;
        w_retry_nx  = r_retry;
        w_tmr_load  = 1'b0;
        w_tmr_en    = 1'b0;
        unique case (r_state)
            ST_NORM: begin
                w_modeS_nx = 1'b0;
                if (userMode) begin
                    w_state_nx = ST_TTR;
                    w_modeS_nx = 1'b1;
                end else begin
                    w_fetchA_nx = userFetch;
                end
            end
            ST_TTR: begin
                w_modeS_nx = 1'b1;
                // Priority: illegal phase recovery, then fail, then commit, then advance.
                if (r_ctr == 2'b11) begin
                    w_ctr_nx = PH0;
                end else if (fail && (r_ctr != PH0)) begin
                    if (r_retry < MAX_R) begin
                        w_state_nx = ST_REC;
                        w_retry_nx = r_retry + 1'b1;
                        w_err_nx   = 1'b1;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_state_nx = ST_FAIL;
                        w_ufail_nx = 1'b1;
                    end
                end else if (r_ctr == PH2) begin
                    w_fetchA_nx = 1'b1;
                    w_retry_nx  = '0;
                    if (!userMode) begin
                        w_state_nx = ST_NORM;
                        w_modeS_nx = 1'b0;
                    end
                end else begin
                    w_ctr_nx = r_ctr + 2'd1;
                end
            end
            ST_REC: begin
                w_modeS_nx = 1'b1;
                w_tmr_en   = 1'b1;
                if (w_tmr_done) begin
                    w_state_nx = ST_TTR;
                end else begin
                    w_err_nx = 1'b1;
                end
            end
            ST_FAIL: begin
                w_modeS_nx = 1'b1;
                w_ufail_nx = 1'b1;
            end
            default: w_state_nx = ST_NORM;
        endcase
    end

    assign modeS    = r_modeS;
    assign fetchA   = r_fetchA;
    assign ctr      = r_ctr;
    assign errFlag  = r_err;
    assign userFail = r_ufail;
    assign retryCnt = r_retry;

endmodule

// File: tb/tb_dytr_seq_ctrl.sv
// Directed bench for dytr_seq_ctrl with REC_CYCLES=4, MAX_RETRY=2.
module tb_dytr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, userMode, userFetch, fail;
    logic       modeS, fetchA, errFlag, userFail;
    logic [1:0] ctr;
    logic [1:0] retryCnt;

    int n_chk = 0;
    int n_err = 0;

    dytr_seq_ctrl #(.REC_CYCLES(4), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .userMode  (userMode),
        .userFetch (userFetch),
        .fail      (fail),
        .modeS     (modeS),
        .fetchA    (fetchA),
        .ctr       (ctr),
        .errFlag   (errFlag),
        .userFail  (userFail),
        .retryCnt  (retryCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int f, input int c,
                           input int e, input int u, input int r);
        chk({tag, ".modeS"},    32'(modeS),    32'(m));
        chk({tag, ".fetchA"},   32'(fetchA),   32'(f));
        chk({tag, ".ctr"},      32'(ctr),      32'(c));
        chk({tag, ".errFlag"},  32'(errFlag),  32'(e));
        chk({tag, ".userFail"}, 32'(userFail), 32'(u));
        chk({tag, ".retryCnt"}, 32'(retryCnt), 32'(r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four REC cycles with errFlag high, then back in TTR at phase 00.
    task automatic rec_episode(input string tag, input int r);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all(tag, 1, 0, 0, 1, 0, r);
        end
        tick();
        chk_all({tag, ".exit"}, 1, 0, 0, 0, 0, r);
    endtask

    initial begin
        reset = 1'b1; userMode = 1'b0; userFetch = 1'b0; fail = 1'b0;

        // 1: reset, then normal-mode fetch passthrough
        repeat (3) tick();
        chk_all("rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        userFetch = 1'b1;
        tick(); chk_all("norm.f1", 0, 1, 0, 0, 0, 0);
        tick(); chk_all("norm.f2", 0, 1, 0, 0, 0, 0);
        userFetch = 1'b0;
        tick(); chk_all("norm.f0", 0, 0, 0, 0, 0, 0);

        // 2: enter TTR, fetch dropped on the switch cycle, three clean triples
        userMode = 1'b1; userFetch = 1'b1;
        tick(); chk_all("ttr.enter", 1, 0, 0, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            tick(); chk_all("ttr.ph1", 1, 0, 1, 0, 0, 0);
            tick(); chk_all("ttr.ph2", 1, 0, 2, 0, 0, 0);
            tick(); chk_all("ttr.commit", 1, 1, 0, 0, 0, 0);
        end
        userFetch = 1'b0;

        // 3: fail at phase 01 -> one recovery, then clean commit clears retry
        tick(); chk_all("r3.ph1", 1, 0, 1, 0, 0, 0);
        fail = 1'b1;
        tick(); chk_all("r3.rec", 1, 0, 0, 1, 0, 1);
        fail = 1'b0;
        rec_episode("r3.hold", 1);
        tick(); chk_all("r3.ph1b", 1, 0, 1, 0, 0, 1);
        tick(); chk_all("r3.ph2b", 1, 0, 2, 0, 0, 1);
        tick(); chk_all("r3.commit", 1, 1, 0, 0, 0, 0);

        // 5a: mode drop at phase 01 is deferred to the commit edge
        tick(); chk_all("m5.ph1", 1, 0, 1, 0, 0, 0);
        userMode = 1'b0;
        tick(); chk_all("m5.ph2", 1, 0, 2, 0, 0, 0);
        tick(); chk_all("m5.commit", 0, 1, 0, 0, 0, 0);
        tick(); chk_all("m5.norm", 0, 0, 0, 0, 0, 0);

        // 5b: mode drop together with fail at phase 10 -> fail wins
        userMode = 1'b1;
        tick(); chk_all("m5b.enter", 1, 0, 0, 0, 0, 0);
        tick(); chk_all("m5b.ph1", 1, 0, 1, 0, 0, 0);
        tick(); chk_all("m5b.ph2", 1, 0, 2, 0, 0, 0);
        userMode = 1'b0; fail = 1'b1;
        tick(); chk_all("m5b.rec", 1, 0, 0, 1, 0, 1);
        fail = 1'b0;
        rec_episode("m5b.hold", 1);
        tick(); chk_all("m5b.ph1b", 1, 0, 1, 0, 0, 1);
        tick(); chk_all("m5b.ph2b", 1, 0, 2, 0, 0, 1);
        tick(); chk_all("m5b.commit", 0, 1, 0, 0, 0, 0);

        // 6: fail at phase 00 ignored; reset during REC clears everything
        userMode = 1'b1;
        tick(); chk_all("r6.enter", 1, 0, 0, 0, 0, 0);
        fail = 1'b1;
        tick(); chk_all("r6.ign", 1, 0, 1, 0, 0, 0);
        fail = 1'b0;
        tick(); chk_all("r6.ph2", 1, 0, 2, 0, 0, 0);
        fail = 1'b1;
        tick(); chk_all("r6.rec", 1, 0, 0, 1, 0, 1);
        fail = 1'b0; reset = 1'b1;
        tick(); chk_all("r6.rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // 4: retries exhausted -> sticky FAIL until reset
        tick(); chk_all("f4.enter", 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            tick(); chk_all("f4.ph1", 1, 0, 1, 0, 0, k - 1);
            tick(); chk_all("f4.ph2", 1, 0, 2, 0, 0, k - 1);
            fail = 1'b1;
            tick(); chk_all("f4.rec", 1, 0, 0, 1, 0, k);
            fail = 1'b0;
            rec_episode("f4.hold", k);
        end
        tick(); chk_all("f4.ph1c", 1, 0, 1, 0, 0, 2);
        tick(); chk_all("f4.ph2c", 1, 0, 2, 0, 0, 2);
        fail = 1'b1;
        tick(); chk_all("f4.fail", 1, 0, 0, 0, 1, 2);
        for (int i = 0; i < 22; i++) begin
            fail = i[0]; userFetch = ~i[0]; userMode = i[1];
            tick(); chk_all("f4.sticky", 1, 0, 0, 0, 1, 2);
        end
        reset = 1'b1;
        tick(); chk_all("f4.rst", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
